// File: rtl/md5_pkg.sv
// Shared widths, FSM encoding and packing helpers for the md5 brute-force candidate source.
package md5_pkg;

    localparam int CHAR_W    = 8;
    localparam int MSG_W     = 512;
    localparam int LEN_W     = 64;
    localparam int FIELD_W   = 448;
    localparam int MAX_CHARS = FIELD_W / CHAR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Char 0 lands in the most significant byte of the L-byte value.
    function automatic logic [FIELD_W-1:0] pack(input logic [FIELD_W-1:0] digits,
                                                input logic [5:0]         len);
        logic [FIELD_W-1:0] field;
        field = '0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (i < int'(len)) begin
                field = {field[FIELD_W-CHAR_W-1:0], digits[CHAR_W*i +: CHAR_W]};
            end
        end
        return field;
    endfunction

    function automatic logic [5:0] clamp_len(input logic [5:0] req, input int max_len);
        if (req == 6'd0) begin
            return 6'd1;
        end
        if (int'(req) > max_len) begin
            return 6'(max_len);
        end
        return req;
    endfunction

endpackage

// File: rtl/md5_candidate_gen_if.sv
// Candidate stream from the generator to the md5core input stage.
interface md5_candidate_gen_if;
    import md5_pkg::*;

    logic             cand_valid;
    logic             cand_ready;
    logic [MSG_W-1:0] message;
    logic [LEN_W-1:0] length;

    modport master (output cand_valid, output message, output length, input cand_ready);
    modport slave  (input cand_valid, input message, input length, output cand_ready);

endinterface

// File: rtl/md5_char_digit.sv
// One odometer cell: a charset digit that wraps CHAR_MAX -> CHAR_MIN.
module md5_char_digit #(
    parameter logic [7:0] CHAR_MIN = 8'h61,
    parameter logic [7:0] CHAR_MAX = 8'h7a
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       inc,
    input  logic       carry_in,
    output logic [7:0] digit,
    output logic       carry_out
);

    // Carry this cell generates when stepped; the top gates it along the chain.
    assign carry_out = (digit == CHAR_MAX);

    // NOTE: sequential state uses non-blocking assignments so all cells update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            digit <= CHAR_MIN;
        end else if (inc && carry_in) begin
            digit <= carry_out ? CHAR_MIN : digit + 8'd1;
        end
    end

endmodule

// File: rtl/md5_candidate_gen.sv
// Enumerates every charset string, shortest first, and streams it packed for md5core.
module md5_candidate_gen
    import md5_pkg::*;
#(
    parameter logic [7:0] CHAR_MIN = 8'h61,
    parameter logic [7:0] CHAR_MAX = 8'h7a,
    parameter int         MAX_LEN  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [5:0]          start_len,
    md5_candidate_gen_if.master cand,
    output logic [63:0]         cand_count,
    output logic                busy,
    output logic                done
);

    state_t               state_q, state_d;
    logic [5:0]           len_q;
    logic [FIELD_W-1:0]   digits;
    logic [MAX_LEN-1:0]   cin;
    logic [MAX_LEN-1:0]   wrap;
    logic                 ripple;
    logic                 carry_first;
    logic                 launch;
    logic                 accept;
    logic                 last;
    logic                 advance;

    assign launch  = start && !stop && (state_q != RUN);
    assign accept  = cand.cand_valid && cand.cand_ready && !stop;
    assign last    = accept && carry_first && (len_q == 6'(MAX_LEN));
    // The final accept leaves the odometer untouched so the payload freezes on the last string.
    assign advance = accept && !last;

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_cell
        md5_char_digit #(
            .CHAR_MIN (CHAR_MIN),
            .CHAR_MAX (CHAR_MAX)
        ) u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (launch),
            .inc       (advance),
            .carry_in  (cin[i]),
            .digit     (digits[CHAR_W*i +: CHAR_W]),
            .carry_out (wrap[i])
        );
    end
    assign digits[FIELD_W-1:CHAR_W*MAX_LEN] = '0;

    // Ripple from the last active char towards char 0; inactive cells see no carry.
    always_comb begin
        ripple = 1'b0;
        cin    = '0;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (i == int'(len_q) - 1) begin
                ripple = 1'b1;
            end else if (i >= int'(len_q)) begin
                ripple = 1'b0;
            end
            cin[i] = ripple;
            ripple = ripple && wrap[i];
        end
        carry_first = ripple;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: if (start) state_d = RUN;
                RUN:        if (last)  state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= 6'd0;
            cand_count <= 64'd0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                len_q <= clamp_len(start_len, MAX_LEN);
            end else if (advance && carry_first) begin
                len_q <= len_q + 6'd1;
            end
            if (launch) begin
                cand_count <= 64'd0;
            end else if (accept) begin
                cand_count <= cand_count + 64'd1;
            end
        end
    end

    assign cand.cand_valid = (state_q == RUN);
    assign cand.message    = {{(MSG_W-FIELD_W){1'b0}}, pack(digits, len_q)};
    assign cand.length     = {{(LEN_W-9){1'b0}}, len_q, 3'b000};
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);

endmodule

// File: tb/tb_md5_candidate_gen.sv
// Scoreboard bench for md5_candidate_gen: default a..z/8 instance and a small a..c/2 instance.
module tb_md5_candidate_gen;
    import md5_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       stop = 1'b0;
    logic       ready = 1'b0;
    logic [5:0] start_len = 6'd0;
    logic [63:0] count_a, count_b;
    logic        busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    md5_candidate_gen_if cif_a ();
    md5_candidate_gen_if cif_b ();
    assign cif_a.cand_ready = ready;
    assign cif_b.cand_ready = ready;

    md5_candidate_gen dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .stop       (stop),
        .start_len  (start_len),
        .cand       (cif_a),
        .cand_count (count_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    md5_candidate_gen #(
        .CHAR_MIN (8'h61),
        .CHAR_MAX (8'h63),
        .MAX_LEN  (2)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .stop       (stop),
        .start_len  (start_len),
        .cand       (cif_b),
        .cand_count (count_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    // Selected-instance view used by all checks.
    logic         sel = 1'b0;
    logic         v_s, busy_s, done_s;
    logic [511:0] msg_s;
    logic [63:0]  len_s, cnt_s;
    always_comb begin
        v_s    = sel ? cif_b.cand_valid : cif_a.cand_valid;
        msg_s  = sel ? cif_b.message    : cif_a.message;
        len_s  = sel ? cif_b.length     : cif_a.length;
        cnt_s  = sel ? count_b          : count_a;
        busy_s = sel ? busy_b           : busy_a;
        done_s = sel ? done_b           : done_a;
    end

    typedef struct {
        logic [511:0] msg;
        logic [63:0]  len;
    } exp_t;

    exp_t sb[$];
    int   md[56];
    int   ml, cmin, cmax, maxlen;
    bit   m_done;
    bit   spot_en;
    int   accepts;
    int   passed = 0;
    int   total  = 0;
    int   cyc;
    bit   bp;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic select_dut(input bit s);
        sel = s;
        cmin   = 32'h61;
        cmax   = s ? 32'h63 : 32'h7a;
        maxlen = s ? 2 : 8;
    endtask

    task automatic model_push();
        exp_t e;
        e.msg = '0;
        for (int i = 0; i < ml; i++) e.msg = (e.msg << 8) | 512'(8'(md[i]));
        e.len = 64'(ml * 8);
        sb.push_back(e);
    endtask

    task automatic model_start(input int req);
        ml = (req == 0) ? 1 : (req > maxlen) ? maxlen : req;
        for (int i = 0; i < 56; i++) md[i] = cmin;
        m_done = 1'b0;
        sb.delete();
        model_push();
    endtask

    task automatic model_advance();
        int i;
        i = ml - 1;
        while (i >= 0 && md[i] == cmax) begin
            md[i] = cmin;
            i--;
        end
        if (i >= 0) md[i]++;
        else if (ml == maxlen) m_done = 1'b1;
        else ml++;
        if (!m_done) model_push();
    endtask

    task automatic spot(input int n);
        case (n)
            1:   begin check("first_a", msg_s, 512'('h61)); check("first_len", 512'(len_s), 512'(8)); end
            26:  check("z_26th", msg_s, 512'('h7a));
            27:  begin check("aa_27th", msg_s, 512'('h6161)); check("aa_len", 512'(len_s), 512'(16)); end
            52:  check("az", msg_s, 512'('h617a));
            53:  check("ba", msg_s, 512'('h6261));
            702: check("zz", msg_s, 512'('h7a7a));
            703: begin check("aaa", msg_s, 512'('h616161)); check("aaa_len", 512'(len_s), 512'(24)); end
            default: ;
        endcase
    endtask

    // Drive one cycle's inputs at the falling edge and score whatever the next rising edge accepts.
    task automatic step(input logic rdy, input bit st = 1'b0);
        exp_t e;
        @(negedge clk);
        start_a = st && !sel;
        start_b = st && sel;
        if (st) start_len = 6'd5;
        stop  = 1'b0;
        ready = rdy;
        if (v_s) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 512'(v_s), 512'(0));
            end else if (ready) begin
                e = sb.pop_front();
                accepts++;
                check("msg", msg_s, e.msg);
                check("len", 512'(len_s), 512'(e.len));
                if (spot_en) spot(accepts);
                model_advance();
            end else begin
                check("hold_msg", msg_s, sb[0].msg);
            end
        end
    endtask

    task automatic do_start(input int req);
        @(negedge clk);
        stop      = 1'b0;
        start_len = 6'(req);
        start_a   = !sel;
        start_b   = sel;
        ready     = 1'b1;
        model_start(req);
        accepts = 0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        stop    = 1'b1;
        ready   = 1'b1;
        sb.delete();
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 512'(v_s), 512'(0));
        check({tag, "_msg"}, msg_s, 512'(0));
        check({tag, "_len"}, 512'(len_s), 512'(0));
        check({tag, "_count"}, 512'(cnt_s), 512'(0));
        check({tag, "_busy"}, 512'(busy_s), 512'(0));
        check({tag, "_done"}, 512'(done_s), 512'(0));
    endtask

    initial begin
        spot_en = 1'b0;
        select_dut(1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("rst_a");
        select_dut(1'b1);
        #1;
        check_zero("rst_b");
        @(negedge clk);
        rst_n = 1'b1;

        // Lengths 1..3 on the default instance, with a stall and an ignored restart.
        select_dut(1'b0);
        spot_en = 1'b1;
        do_start(1);
        cyc = 0;
        bp  = 1'b0;
        while (accepts < 705 && cyc < 2000) begin
            if (accepts == 300 && !bp) begin
                repeat (5) step(1'b0);
                bp = 1'b1;
            end else begin
                step(1'b1, accepts == 100);
            end
            cyc++;
        end
        spot_en = 1'b0;
        check("run_accepts", 512'(accepts), 512'(705));
        step(1'b0);
        check("run_count", 512'(cnt_s), 512'(accepts));

        do_stop();
        check("stop1_valid", 512'(v_s), 512'(0));
        check("stop1_count", 512'(cnt_s), 512'(705));

        // Clamp of zero length, then stop on an accepting cycle.
        do_start(0);
        cyc = 0;
        while (accepts < 10 && cyc < 50) begin
            step(1'b1);
            cyc++;
        end
        do_stop();
        check("stop_valid", 512'(v_s), 512'(0));
        check("stop_busy", 512'(busy_s), 512'(0));
        check("stop_count", 512'(cnt_s), 512'(10));

        // Over-long request clamps to MAX_LEN.
        do_start(63);
        repeat (3) step(1'b1);
        do_stop();

        // Reset while running.
        do_start(3);
        repeat (5) step(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst_n = 1'b1;
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", 512'(v_s), 512'(0));
        end

        // Exhaust the small space.
        select_dut(1'b1);
        do_start(1);
        cyc = 0;
        while (!done_s && cyc < 40) begin
            step(1'b1);
            cyc++;
        end
        check("small_done", 512'(done_s), 512'(1));
        check("small_accepts", 512'(accepts), 512'(12));
        check("small_valid", 512'(v_s), 512'(0));
        check("small_busy", 512'(busy_s), 512'(0));
        check("small_count", 512'(cnt_s), 512'(12));
        check("small_frozen", msg_s, 512'('h6363));
        check("small_frozen_len", 512'(len_s), 512'(16));

        // Restart from DONE.
        do_start(2);
        repeat (4) step(1'b1);
        check("restart_accepts", 512'(accepts), 512'(4));
        do_stop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
